// File: rtl/ycconfig_loader_pkg.sv
// Shared definitions for the configuration-chain loader: cell code values,
// FSM states and the bit-order helper used when serialising a code.
package ycconfig_loader_pkg;

  localparam int CODE_W   = 3;
  localparam int IDX_LAST = CODE_W - 1;

  localparam logic [CODE_W-1:0] CODE_SPACE  = 3'b000;
  localparam logic [CODE_W-1:0] CODE_PLUS   = 3'b001;
  localparam logic [CODE_W-1:0] CODE_HSHORT = 3'b010;
  localparam logic [CODE_W-1:0] CODE_VSHORT = 3'b011;
  localparam logic [CODE_W-1:0] CODE_ONE    = 3'b100;
  localparam logic [CODE_W-1:0] CODE_ZERO   = 3'b101;
  localparam logic [CODE_W-1:0] CODE_YES    = 3'b110;
  localparam logic [CODE_W-1:0] CODE_NO     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_e;

  // Codes go out MSB first: bit index 0 carries code[2].
  function automatic logic code_bit(input logic [CODE_W-1:0] code, input logic [1:0] idx);
    return code[2'd2 - idx];
  endfunction

endpackage

// File: rtl/ycconfig_loader.sv
// Serial loader for a chain of 3-bit configuration cells: shifts one host code
// out on cbitin/confclk per request and returns the code pushed off the far end.
module ycconfig_loader
  import ycconfig_loader_pkg::*;
#(
  parameter int HALF = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic              out_valid,
  output logic [CODE_W-1:0] out_code,
  input  logic              out_ready,
  output logic              confclk,
  output logic              cbitin,
  input  logic              cbitret,
  output logic              busy
);

  localparam int PW = 4;
  localparam logic [PW-1:0] PHASE_LAST = PW'(HALF - 1);

  state_e            state, state_nxt;
  logic [PW-1:0]     phase;
  logic [1:0]        idx;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] ret_q;
  logic              phase_done;
  logic              last_bit;
  logic              accept;

  assign phase_done = (phase == PHASE_LAST);
  assign last_bit   = (idx == 2'(IDX_LAST));
  assign accept     = in_valid & in_ready;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)     state_nxt = ST_LOW;
      ST_LOW:  if (phase_done) state_nxt = ST_HIGH;
      ST_HIGH: if (phase_done) state_nxt = last_bit ? ST_IDLE : ST_LOW;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Returned data taken in the same IDLE cycle frees the loader at once, so a
  // streaming host spends exactly one IDLE cycle between codes.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      ST_IDLE: in_ready = ~out_valid | out_ready;
      default: busy     = 1'b1;
    endcase
  end

  // Shift datapath; confclk and cbitin are registered so the chain sees clean edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase     <= '0;
      idx       <= '0;
      code_q    <= CODE_SPACE;
      ret_q     <= CODE_SPACE;
      confclk   <= 1'b0;
      cbitin    <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= CODE_SPACE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
          if (accept) begin
            code_q <= in_code;
            idx    <= '0;
            phase  <= '0;
            cbitin <= code_bit(in_code, 2'd0);
          end
        end
        ST_LOW: begin
          if (phase_done) begin
            phase   <= '0;
            confclk <= 1'b1;
            // far-end bit is sampled before the chain shifts on this rising edge
            ret_q   <= {ret_q[CODE_W-2:0], cbitret};
          end else begin
            phase <= phase + PW'(1);
          end
        end
        ST_HIGH: begin
          if (phase_done) begin
            phase   <= '0;
            confclk <= 1'b0;
            if (last_bit) begin
              out_valid <= 1'b1;
              out_code  <= ret_q;
            end else begin
              idx    <= idx + 2'd1;
              cbitin <= code_bit(code_q, idx + 2'd1);
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        default: begin
          phase   <= '0;
          confclk <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ycconfig_loader.sv
// Directed bench: HALF=2 loader driving a 1..3-cell modelled chain, plus a
// HALF=1 loader streaming codes back-to-back into a single cell.
module tb_ycconfig_loader;
  import ycconfig_loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  // HALF=2 instance and its chain
  logic       iv2, or2, ir2, ov2, cc2, cb2, cr2, busy2, clr2;
  logic [2:0] ic2, oc2, log2;
  logic [2:0][2:0] cell2;
  logic [1:0] sel2;
  int         pcnt2;

  // HALF=1 instance and its single cell
  logic       iv1, or1, ir1, ov1, cc1, cb1, cr1, busy1, clr1;
  logic [2:0] ic1, oc1, cell1;
  int         pcnt1;

  ycconfig_loader #(.HALF(2)) u_h2 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv2), .in_code(ic2), .in_ready(ir2),
    .out_valid(ov2), .out_code(oc2), .out_ready(or2), .confclk(cc2),
    .cbitin(cb2), .cbitret(cr2), .busy(busy2));

  ycconfig_loader #(.HALF(1)) u_h1 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv1), .in_code(ic1), .in_ready(ir1),
    .out_valid(ov1), .out_code(oc1), .out_ready(or1), .confclk(cc1),
    .cbitin(cb1), .cbitret(cr1), .busy(busy1));

  assign cr2 = cell2[sel2][2];
  assign cr1 = cell1[2];

  always @(posedge cc2 or posedge clr2) begin
    if (clr2) begin
      cell2 <= '0;
      log2  <= '0;
      pcnt2 <= 0;
    end else begin
      cell2[0] <= {cell2[0][1:0], cb2};
      cell2[1] <= {cell2[1][1:0], cell2[0][2]};
      cell2[2] <= {cell2[2][1:0], cell2[1][2]};
      log2     <= {log2[1:0], cb2};
      pcnt2    <= pcnt2 + 1;
    end
  end

  always @(posedge cc1 or posedge clr1) begin
    if (clr1) begin
      cell1 <= '0;
      pcnt1 <= 0;
    end else begin
      cell1 <= {cell1[1:0], cb1};
      pcnt1 <= pcnt1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear2();
    clr2 = 1'b1;
    #1 clr2 = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue2(input logic [2:0] code);
    int t = 0;
    while (!ir2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("issue2_ready", 32'(t < 100), 1);
    iv2 = 1'b1;
    ic2 = code;
    @(negedge clk);
    iv2 = 1'b0;
    ic2 = ~code;
  endtask

  task automatic collect2(input bit ack, output int busy_c, output int hi_c, output int max_hi,
                          output int min_hi, output int min_lo, output logic [2:0] ret);
    int   t = 0, run = 0, cbchg = 0;
    logic prev = 1'b0;
    logic cbp;
    busy_c = 0; hi_c = 0; max_hi = 0; min_hi = 99; min_lo = 99;
    cbp = cb2;
    while (!ov2 && t < 200) begin
      if (busy2) busy_c++;
      if (cc2) begin
        hi_c++;
        if (cb2 !== cbp) cbchg++;
      end
      if (cc2 == prev) run++;
      else begin
        if (prev) begin
          if (run > max_hi) max_hi = run;
          if (run < min_hi) min_hi = run;
        end else if (run > 0 && run < min_lo) min_lo = run;
        run = 1;
      end
      prev = cc2;
      cbp  = cb2;
      @(negedge clk);
      t++;
    end
    if (prev) begin
      if (run > max_hi) max_hi = run;
      if (run < min_hi) min_hi = run;
    end
    chk("collect2_done", 32'(ov2), 1);
    chk("cbitin_stable_hi", cbchg, 0);
    ret = oc2;
    if (ack) begin
      or2 = 1'b1;
      @(negedge clk);
      or2 = 1'b0;
      chk("ack_clears_ov", 32'(ov2), 0);
      chk("ack_ready", 32'(ir2), 1);
    end
  endtask

  initial begin
    int bc, hc, mxh, mnh, mnl, p0, t, bad, k, nret;
    logic [2:0] r;
    logic [2:0] seq [6];
    logic [2:0] eret [6];
    logic [2:0] c1 [4];
    logic [2:0] rets [4];
    int acc [4];

    reset_n = 1'b0;
    iv2 = 0; ic2 = '0; or2 = 0; sel2 = 2'd0;
    iv1 = 0; ic1 = '0; or1 = 0;
    clr2 = 1'b1; clr1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_confclk", 32'(cc2), 0);
    chk("rst_cbitin", 32'(cb2), 0);
    chk("rst_out_valid", 32'(ov2), 0);
    chk("rst_out_code", 32'(oc2), 0);
    chk("rst_busy", 32'(busy2), 0);
    chk("rst_confclk_h1", 32'(cc1), 0);
    reset_n = 1'b1; clr2 = 1'b0; clr1 = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 32'(ir2), 1);
    chk("rel_in_ready_h1", 32'(ir1), 1);
    chk("rel_no_pulse", pcnt2, 0);

    // one cell, HSHORT then ZERO
    p0 = pcnt2;
    issue2(CODE_HSHORT);
    collect2(1, bc, hc, mxh, mnh, mnl, r);
    chk("one_pulses", pcnt2 - p0, 3);
    chk("one_busy_cycles", bc, 12);
    chk("one_hi_cycles", hc, 6);
    chk("one_max_hi", mxh, 2);
    chk("one_min_hi", mnh, 2);
    chk("one_min_lo", mnl, 2);
    chk("one_cbitin_seq", 32'(log2), 32'(CODE_HSHORT));
    chk("one_cell", 32'(cell2[0]), 32'(CODE_HSHORT));
    chk("one_ret0", 32'(r), 32'(CODE_SPACE));
    issue2(CODE_ZERO);
    collect2(1, bc, hc, mxh, mnh, mnl, r);
    chk("one_ret1", 32'(r), 32'(CODE_HSHORT));
    chk("one_cell1", 32'(cell2[0]), 32'(CODE_ZERO));

    // three-cell chain
    clear2();
    sel2 = 2'd2;
    seq  = '{CODE_ONE, CODE_NO, CODE_PLUS, CODE_SPACE, CODE_SPACE, CODE_SPACE};
    eret = '{CODE_SPACE, CODE_SPACE, CODE_SPACE, CODE_ONE, CODE_NO, CODE_PLUS};
    for (int i = 0; i < 6; i++) begin
      issue2(seq[i]);
      collect2(1, bc, hc, mxh, mnh, mnl, r);
      chk($sformatf("chain3_ret%0d", i), 32'(r), 32'(eret[i]));
      if (i == 2) begin
        chk("chain3_far", 32'(cell2[2]), 32'(CODE_ONE));
        chk("chain3_mid", 32'(cell2[1]), 32'(CODE_NO));
        chk("chain3_near", 32'(cell2[0]), 32'(CODE_PLUS));
      end
    end

    // backpressure on returned data
    clear2();
    sel2 = 2'd0;
    issue2(CODE_ONE);
    collect2(0, bc, hc, mxh, mnh, mnl, r);
    p0 = pcnt2;
    iv2 = 1'b1;
    ic2 = CODE_YES;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!ov2 || ir2 || busy2 || oc2 !== CODE_SPACE) bad++;
    end
    chk("stall_hold", bad, 0);
    chk("stall_no_pulse", pcnt2 - p0, 0);
    or2 = 1'b1;
    @(negedge clk);
    or2 = 1'b0;
    iv2 = 1'b0;
    chk("resume_busy", 32'(busy2), 1);
    chk("resume_ov", 32'(ov2), 0);
    collect2(1, bc, hc, mxh, mnh, mnl, r);
    chk("resume_ret", 32'(r), 32'(CODE_ONE));
    chk("resume_cell", 32'(cell2[0]), 32'(CODE_YES));

    // reset in HIGH of bit 1
    clear2();
    p0 = pcnt2;
    issue2(CODE_NO);
    t = 0;
    while (!(cc2 && (pcnt2 - p0) == 2) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reach_hi1", 32'(t < 100), 1);
    reset_n = 1'b0;
    #1;
    chk("abort_confclk", 32'(cc2), 0);
    chk("abort_out_valid", 32'(ov2), 0);
    chk("abort_cbitin", 32'(cb2), 0);
    chk("abort_busy", 32'(busy2), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    p0 = pcnt2;
    repeat (3) @(negedge clk);
    chk("abort_no_pulse", pcnt2 - p0, 0);
    chk("abort_ready", 32'(ir2), 1);
    clear2();
    issue2(CODE_VSHORT);
    collect2(1, bc, hc, mxh, mnh, mnl, r);
    chk("abort_reload_cell", 32'(cell2[0]), 32'(CODE_VSHORT));
    chk("abort_reload_pulses", pcnt2, 3);

    // HALF=1 streaming, in_code scrambled while busy
    clr1 = 1'b1;
    #1 clr1 = 1'b0;
    c1 = '{CODE_YES, CODE_VSHORT, CODE_ZERO, CODE_SPACE};
    or1 = 1'b1;
    k = 0; nret = 0; t = 0;
    while (nret < 4 && t < 200) begin
      if (ov1) begin
        rets[nret] = oc1;
        nret++;
      end
      if (ir1) begin
        if (k < 4) begin
          iv1 = 1'b1;
          ic1 = c1[k];
          acc[k] = t;
          k++;
        end else iv1 = 1'b0;
      end else ic1 = 3'($urandom_range(0, 7));
      @(negedge clk);
      t++;
    end
    iv1 = 1'b0;
    chk("h1_done", nret, 4);
    for (int i = 1; i < 4; i++) chk($sformatf("h1_period%0d", i), acc[i] - acc[i-1], 7);
    chk("h1_ret0", 32'(rets[0]), 32'(CODE_SPACE));
    chk("h1_ret1", 32'(rets[1]), 32'(CODE_YES));
    chk("h1_ret2", 32'(rets[2]), 32'(CODE_VSHORT));
    chk("h1_ret3", 32'(rets[3]), 32'(CODE_ZERO));
    chk("h1_cell", 32'(cell1), 32'(CODE_SPACE));
    chk("h1_pulses", pcnt1, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
